// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO and its read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned OCC_WIDTH      = 2;

    // Occupancy encoding of the 2-entry read buffer.
    localparam logic [OCC_WIDTH-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_WIDTH-1:0] OCC_HALF  = 2'd1;
    localparam logic [OCC_WIDTH-1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry circular output buffer with occupancy tracking and synchronous flush.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [OCC_WIDTH-1:0]  occ,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  head;
    logic                  tail;

    // Storage, pointers and occupancy; flush wins over any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= OCC_EMPTY;
        end else if (flush) begin
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= OCC_EMPTY;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ <= occ + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
        end
    end

    assign head_data = mem[head];
    assign full      = (occ == OCC_FULL);

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain adapter: turns the FIFO's one-cycle-latency pop port into a
// full-throughput valid/ready stream, counting delivered words.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  buf_full
);

    localparam int unsigned CRED_WIDTH = OCC_WIDTH + 1;

    logic [OCC_WIDTH-1:0]  occ;
    logic                  inflight;
    logic                  pop;
    logic                  capture;
    logic [CRED_WIDTH-1:0] credit;
    logic [CNT_WIDTH-1:0]  cnt_q;

    assign pop     = m_valid & m_ready;
    assign capture = inflight & ~flush;

    // Buffered plus in-flight words after this cycle's pop must leave room for one more.
    assign credit     = CRED_WIDTH'(occ) + CRED_WIDTH'(inflight) - CRED_WIDTH'(pop);
    assign fifo_rd_en = ~fifo_empty & ~flush & (credit < CRED_WIDTH'(OCC_FULL));

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (capture),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .flush     (flush),
        .occ       (occ),
        .head_data (m_data),
        .full      (buf_full)
    );

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight <= 1'b0;
            cnt_q    <= '0;
        end else begin
            inflight <= fifo_rd_en;
            cnt_q    <= cnt_q + CNT_WIDTH'(pop);
        end
    end

    assign m_valid  = (occ != OCC_EMPTY);
    assign word_cnt = cnt_q;

`ifndef SYNTHESIS
    a_credit_bound: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        (CRED_WIDTH'(occ) + CRED_WIDTH'(inflight)) <= CRED_WIDTH'(OCC_FULL));
    a_no_pop_when_empty: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(fifo_rd_en && fifo_empty));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO stand-in plus a latency-level scoreboard.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;
    logic          buf_full;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .word_cnt     (word_cnt),
        .buf_full     (buf_full)
    );

    // A word popped from the FIFO becomes visible downstream two cycles later.
    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } ent_t;

    ent_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [CW-1:0] exp_cnt;
    int            total = 0;
    int            bad   = 0;
    int            now   = 0;
    int            first_valid, deliv_n, deliv_last, gaps, rd_n;
    logic [DW-1:0] first_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear_stats();
        first_valid = -1;
        deliv_n     = 0;
        deliv_last  = 0;
        gaps        = 0;
        rd_n        = 0;
        first_data  = '0;
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + DW'(i)));
        fifo_empty = 1'b0;
    endtask

    // One clock: check at negedge against the model, then advance the FIFO stand-in.
    task automatic step();
        int   ready_n;
        logic v_exp, pop_exp, rd_exp, pend;
        ent_t e;
        @(negedge rd_clk);
        pend = 1'b0;
        if (!rd_rst_n) begin
            check("rst_rd_en", fifo_rd_en, 0);
        end else begin
            ready_n = 0;
            foreach (exp_q[i]) if (exp_q[i].rdy <= now) ready_n++;
            v_exp   = (ready_n > 0);
            pop_exp = v_exp && m_ready;
            rd_exp  = !fifo_empty && !flush && ((exp_q.size() - (pop_exp ? 1 : 0)) < 2);
            check("m_valid", m_valid, v_exp);
            check("buf_full", buf_full, ready_n == 2);
            check("fifo_rd_en", fifo_rd_en, rd_exp);
            check("word_cnt", word_cnt, exp_cnt);
            if (v_exp) check("m_data", m_data, exp_q[0].data);
            if (m_valid && first_valid < 0) first_valid = now;
            if (m_valid && m_ready) begin
                if (deliv_n == 0) first_data = m_data;
                if (deliv_n > 0 && now != deliv_last + 1) gaps++;
                deliv_n++;
                deliv_last = now;
            end
            if (fifo_rd_en) rd_n++;
            if (pop_exp) begin
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (flush) exp_q.delete();
            if (fifo_rd_en && fifo_q.size() > 0) begin
                e.data = fifo_q[0];
                e.rdy  = now + 2;
                exp_q.push_back(e);
                pend = 1'b1;
            end
        end
        @(posedge rd_clk);
        #1;
        if (pend) fifo_rd_data = fifo_q.pop_front();
        else      fifo_rd_data = DW'($urandom);
        fifo_empty = (fifo_q.size() == 0);
        now++;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (exp_q.size() != 0 || fifo_q.size() != 0); i++) step();
        check("drain_done", exp_q.size() + fifo_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rd_rst_n     = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        flush        = 1'b0;
        m_ready      = 1'b0;
        exp_cnt      = '0;
        clear_stats();
        repeat (2) @(posedge rd_clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_buf_full", buf_full, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        rd_rst_n = 1'b1;
        repeat (2) step();

        // Streaming 8 preloaded words at full rate.
        clear_stats();
        m_ready = 1'b1;
        t0 = now;
        load(8, 4'h1);
        drain(30);
        check("t1_first_valid", first_valid - t0, 2);
        check("t1_count", deliv_n, 8);
        check("t1_gaps", gaps, 0);
        check("t1_word_cnt", word_cnt, 8);

        // Backpressure: only two words fetched, head held.
        clear_stats();
        m_ready = 1'b0;
        load(5, 4'h1);
        repeat (6) step();
        check("t2_pops", rd_n, 2);
        check("t2_full", buf_full, 1);
        check("t2_hold", m_data, 1);
        clear_stats();
        m_ready = 1'b1;
        drain(20);
        check("t2_count", deliv_n, 5);
        check("t2_gaps", gaps, 0);
        check("t2_word_cnt", word_cnt, 13);

        // Ready toggling every cycle.
        clear_stats();
        load(10, 4'h6);
        for (int i = 0; i < 60 && (exp_q.size() != 0 || fifo_q.size() != 0); i++) begin
            m_ready = i[0];
            step();
        end
        check("t3_count", deliv_n, 10);
        check("t3_word_cnt", word_cnt, 23);

        // Flush with one buffered and one in-flight word.
        m_ready = 1'b0;
        load(4, 4'h1);
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4a_valid", m_valid, 0);
        clear_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 10 && deliv_n == 0; i++) step();
        check("t4a_next", first_data, 3);
        m_ready = 1'b0;
        load(2, 4'h5);
        for (int i = 0; i < 10 && !buf_full; i++) step();
        check("t4b_full", buf_full, 1);
        // Flush with a full buffer and a same-cycle accept.
        flush   = 1'b1;
        m_ready = 1'b1;
        step();
        flush   = 1'b0;
        check("t4b_valid", m_valid, 0);
        check("t4b_word_cnt", word_cnt, 25);
        clear_stats();
        drain(20);
        check("t4b_next", first_data, 6);
        check("t4b_count", deliv_n, 1);

        // Counter wrap.
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFE;
        check("t5_preset", word_cnt, 16'hFFFE);
        load(3, 4'h2);
        drain(20);
        check("t5_wrap", word_cnt, 1);

        // Reset in the middle of a burst with a pop in flight.
        m_ready = 1'b1;
        load(10, 4'h3);
        repeat (4) step();
        rd_rst_n = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        #1;
        check("t6_m_valid", m_valid, 0);
        check("t6_m_data", m_data, 0);
        check("t6_word_cnt", word_cnt, 0);
        check("t6_buf_full", buf_full, 0);
        check("t6_fifo_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) step();
        rd_rst_n = 1'b1;
        clear_stats();
        repeat (5) step();
        check("t6_no_stale", deliv_n, 0);
        load(3, 4'h9);
        drain(20);
        check("t6_word_cnt_after", word_cnt, 3);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8)
                load(int'($urandom_range(1, 3)), DW'($urandom));
            step();
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
